// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch queue: FSM encoding,
// default sizing and the decode bubble instruction.
package fetch_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned DEPTH_DEF = 4;

  // addi x0, x0, 0: what decode inserts when no fetch entry is available
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {pc, pc+4, instr} tuples; the head entry is read
// straight out of the storage flops.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 96
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  input  logic                     clear_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [WIDTH-1:0]         head_data_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Clear wins over any push or pop in the same cycle
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) tail_d = tail_q + PTR_W'(1);
      if (pop_i)  head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push_i && !clear_i) mem_q[tail_q] <= push_data_i;
    end
  end

  assign count_o     = count_q;
  assign head_data_o = mem_q[head_q];

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: issues one outstanding request at a time to instruction memory
// and queues the responses for decode; flush discards queued and in-flight work.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned XLEN  = XLEN_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_in,
  input  logic            pc_valid,
  output logic            pc_ready,
  input  logic            flush,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_4,
  output logic [XLEN-1:0] if_instr
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned ENT_W = 3 * XLEN;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic [ENT_W-1:0] head_data;
  logic            push;
  logic            pop;
  logic            issue;

  assign push       = (state_q == WAIT) && imem_rvalid && !flush;
  assign pop        = if_valid && if_ready && !flush;
  assign count_next = count + CNT_W'(push) - CNT_W'(pop);

  // A new issue must leave room for its own response after this cycle's push/pop
  assign pc_ready = reset && !flush
                  && ((state_q == IDLE) || ((state_q == WAIT) && imem_rvalid))
                  && (count_next < CNT_W'(DEPTH));
  assign issue     = pc_valid && pc_ready;
  assign imem_req  = issue;
  assign imem_addr = pc_in;

  always_comb begin
    state_d   = state_q;
    pend_pc_d = pend_pc_q;
    if (issue) pend_pc_d = pc_in;
    if (flush) begin
      if (state_q == WAIT) state_d = imem_rvalid ? IDLE : DROP;
    end else begin
      unique case (state_q)
        IDLE:    if (issue) state_d = WAIT;
        WAIT:    if (imem_rvalid) state_d = issue ? WAIT : IDLE;
        DROP:    if (imem_rvalid) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .push_i      (push),
    .push_data_i ({pend_pc_q, pend_pc_q + XLEN'(4), imem_rdata}),
    .pop_i       (pop),
    .clear_i     (flush),
    .count_o     (count),
    .head_data_o (head_data)
  );

  assign if_valid = (count != '0);
  assign if_pc    = head_data[3*XLEN-1 -: XLEN];
  assign if_pc_4  = head_data[2*XLEN-1 -: XLEN];
  assign if_instr = head_data[XLEN-1 -: XLEN];

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Cycle-table bench for instr_fetch_queue with a scoreboard of expected
// fetch tuples, plus hand sequences for pc+4 wrap and reset while waiting.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_pc_4;
  logic [31:0] if_instr;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        pv;
    logic [31:0] pc;
    logic        rv;
    logic        fl;
    logic        ifr;
    logic        exp_rdy;
    logic        exp_ifv;
  } vec_t;

  vec_t        vecs[$];
  logic [95:0] sb[$];
  logic [31:0] out_pc = 32'h0;

  always #5 clk = ~clk;

  instr_fetch_queue dut (
    .clk         (clk),
    .reset       (reset),
    .pc_in       (pc_in),
    .pc_valid    (pc_valid),
    .pc_ready    (pc_ready),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_pc       (if_pc),
    .if_pc_4     (if_pc_4),
    .if_instr    (if_instr)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0013;
  endfunction

  function automatic void add(input logic pv, input logic [31:0] pc, input logic rv,
                              input logic fl, input logic ifr,
                              input logic exp_rdy, input logic exp_ifv);
    vec_t v;
    v.pv = pv; v.pc = pc; v.rv = rv; v.fl = fl; v.ifr = ifr;
    v.exp_rdy = exp_rdy; v.exp_ifv = exp_ifv;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, check combinational and head outputs, advance
  task automatic apply_vec(input vec_t v);
    logic [95:0] e;
    pc_valid    = v.pv;
    pc_in       = v.pc;
    imem_rvalid = v.rv;
    imem_rdata  = instr_of(out_pc);
    flush       = v.fl;
    if_ready    = v.ifr;
    #1;
    check("pc_ready", 32'(pc_ready), 32'(v.exp_rdy));
    check("imem_req", 32'(imem_req), 32'(v.pv & v.exp_rdy));
    if (v.pv && v.exp_rdy) check("imem_addr", imem_addr, v.pc);
    check("if_valid", 32'(if_valid), 32'(v.exp_ifv));
    if (v.fl) begin
      sb.delete();
    end else if (v.exp_ifv && v.ifr) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_underflow: got pop with if_pc %h, expected no entry", if_pc);
      end else begin
        e = sb.pop_front();
        check("if_pc",    if_pc,    e[95:64]);
        check("if_pc_4",  if_pc_4,  e[63:32]);
        check("if_instr", if_instr, e[31:0]);
      end
    end
    if (v.pv && v.exp_rdy) begin
      sb.push_back({v.pc, v.pc + 32'd4, instr_of(v.pc)});
      out_pc = v.pc;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b0;
    pc_valid    = 1'b1;
    pc_in       = 32'h123;
    flush       = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    if_ready    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc_ready", 32'(pc_ready), 32'h0);
    check("rst_imem_req", 32'(imem_req), 32'h0);
    check("rst_if_valid", 32'(if_valid), 32'h0);
    check("rst_if_pc",    if_pc,    32'h0);
    check("rst_if_pc_4",  if_pc_4,  32'h0);
    check("rst_if_instr", if_instr, 32'h0);
    pc_valid    = 1'b0;
    imem_rvalid = 1'b0;
    reset       = 1'b1;
    @(posedge clk);
    #1;

    // pv, pc, rv, fl, ifr, exp_rdy, exp_ifv
    // single-cycle memory, decode never stalls
    add(1, 32'h0,   0, 0, 1, 1, 0);
    add(1, 32'h4,   1, 0, 1, 1, 0);
    add(1, 32'h8,   1, 0, 1, 1, 1);
    add(0, 32'h0,   1, 0, 1, 1, 1);
    add(0, 32'h0,   0, 0, 1, 1, 1);
    add(0, 32'h0,   0, 0, 1, 1, 0);
    // decode stalled: four entries fill, then one pop frees a slot
    add(1, 32'h10,  0, 0, 0, 1, 0);
    add(1, 32'h14,  1, 0, 0, 1, 0);
    add(1, 32'h18,  1, 0, 0, 1, 1);
    add(1, 32'h1C,  1, 0, 0, 1, 1);
    add(1, 32'h20,  1, 0, 0, 0, 1);
    add(1, 32'h20,  0, 0, 0, 0, 1);
    add(1, 32'h20,  0, 0, 1, 1, 1);
    add(0, 32'h0,   1, 0, 0, 0, 1);
    add(0, 32'h0,   0, 0, 1, 1, 1);
    add(0, 32'h0,   0, 0, 1, 1, 1);
    add(0, 32'h0,   0, 0, 1, 1, 1);
    add(0, 32'h0,   0, 0, 1, 1, 1);
    add(0, 32'h0,   0, 0, 1, 1, 0);
    // 3-cycle latency, flush one cycle after the request
    add(1, 32'h40,  0, 0, 1, 1, 0);
    add(0, 32'h0,   0, 1, 1, 0, 0);
    add(1, 32'h100, 0, 0, 1, 0, 0);
    add(1, 32'h100, 1, 0, 1, 0, 0);
    add(1, 32'h100, 0, 0, 1, 1, 0);
    add(0, 32'h0,   0, 0, 1, 0, 0);
    add(0, 32'h0,   1, 0, 1, 1, 0);
    add(0, 32'h0,   0, 0, 1, 1, 1);
    add(0, 32'h0,   0, 0, 1, 1, 0);
    // flush together with response and new pc
    add(1, 32'h200, 0, 0, 0, 1, 0);
    add(1, 32'h204, 1, 1, 0, 0, 0);
    add(1, 32'h204, 0, 0, 0, 1, 0);
    add(0, 32'h0,   1, 0, 0, 1, 0);
    add(0, 32'h0,   0, 0, 1, 1, 1);
    add(0, 32'h0,   0, 0, 0, 1, 0);
    // flush with queued entries and a concurrent pop request
    add(1, 32'h300, 0, 0, 0, 1, 0);
    add(1, 32'h304, 1, 0, 0, 1, 0);
    add(0, 32'h0,   1, 0, 0, 1, 1);
    add(0, 32'h0,   0, 1, 1, 0, 1);
    add(0, 32'h0,   0, 0, 1, 1, 0);

    for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i]);

    // pc+4 wraps past the top of the address space
    vecs.delete();
    add(1, 32'hFFFF_FFFC, 0, 0, 0, 1, 0);
    add(0, 32'h0,         1, 0, 0, 1, 0);
    add(0, 32'h0,         0, 0, 1, 1, 1);
    apply_vec(vecs[0]);
    apply_vec(vecs[1]);
    check("wrap_if_pc",   if_pc,   32'hFFFF_FFFC);
    check("wrap_if_pc_4", if_pc_4, 32'h0000_0000);
    apply_vec(vecs[2]);

    // reset while a request is outstanding; the late response is ignored
    vecs.delete();
    add(1, 32'h500, 0, 0, 0, 1, 0);
    apply_vec(vecs[0]);
    pc_valid = 1'b0;
    reset    = 1'b0;
    #1;
    check("midwait_rst_pc_ready", 32'(pc_ready), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    sb.delete();
    imem_rvalid = 1'b1;
    imem_rdata  = instr_of(32'h500);
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    check("late_rsp_if_valid", 32'(if_valid), 32'h0);
    check("late_rsp_pc_ready", 32'(pc_ready), 32'h1);
    @(posedge clk);
    #1;
    check("late_rsp_if_valid2", 32'(if_valid), 32'h0);
    check("sb_empty", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
